bus_master_port: RTL

Core-side initiator for the shared two-core RAM bus. It accepts load/store commands from one core's pipeline into a small queue and drives that core's request/rw/address/data lines toward the bus arbiter. It holds each request stable until the arbiter grants it, then returns a one-cycle response carrying read data. One instance sits between each core and its `coreN_*` port on the bus.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/bus_master_port_if.sv | 40 ++++
 rtl/bus_cmd_fifo.sv | 57 +++++
 rtl/bus_master_port.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, rw encoding, command record and FSM states for the RAM bus master port
package bus_pkg;

  localparam int BUS_ADDR_W = 9;
  localparam int BUS_DATA_W = 8;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef struct packed {
    logic                  rw;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bus_master_state_t;

endpackage

// File: rtl/bus_master_port_if.sv
// rtl/bus_master_port_if.sv - core command/response and RAM bus signals of one bus_master_port
// master = the port itself, slave = the core pipeline plus the bus arbiter around it.
interface bus_master_port_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_rw;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic              bus_request;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_data_in;
  logic              bus_grant;
  logic [DATA_W-1:0] bus_data_out;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data, bus_grant, bus_data_out,
    output cmd_ready, rsp_valid, rsp_rw, rsp_data, rsp_err,
    output bus_request, bus_rw, bus_address, bus_data_in
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data, bus_grant, bus_data_out,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_data, rsp_err,
    input  bus_request, bus_rw, bus_address, bus_data_in
  );

endinterface

// File: rtl/bus_cmd_fifo.sv
// rtl/bus_cmd_fifo.sv - synchronous command queue with wrap-around pointers (DEPTH power of two)
module bus_cmd_fifo
  import bus_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = bus_cmd_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // The extra MSB on each pointer tells a full queue apart from an empty one.
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  entry_t         mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - core-side initiator: queues load/store commands and drives one core port of the RAM bus
// BUS_MASTER_TIMEOUT_EN adds a REQ watchdog that retires an ungranted request with rsp_err.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  bus_master_port_if.master bif
);

  bus_master_state_t state_q, state_d;

  logic              bus_request_q, bus_request_d;
  logic              bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0] bus_address_q, bus_address_d;
  logic [DATA_W-1:0] bus_data_in_q, bus_data_in_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_rw_q, rsp_rw_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  bus_cmd_t push_cmd, head_cmd, next_cmd;
  logic     push, pop, full, empty, have_cmd;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rsp_err_q, rsp_err_d;
`endif

  assign push     = bif.cmd_valid && !full;
  assign push_cmd = {bif.cmd_rw, bif.cmd_addr, bif.cmd_data};

  // A command landing in an empty queue is issued straight from the inputs,
  // so bus_request rises the cycle after acceptance.
  assign have_cmd = !empty || push;
  assign next_cmd = empty ? push_cmd : head_cmd;

  bus_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (bus_cmd_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head_cmd),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d       = state_q;
    bus_request_d = bus_request_q;
    bus_rw_d      = bus_rw_q;
    bus_address_d = bus_address_q;
    bus_data_in_d = bus_data_in_q;
    rsp_valid_d   = 1'b0;
    rsp_rw_d      = rsp_rw_q;
    rsp_data_d    = rsp_data_q;
    pop           = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
    rsp_err_d     = rsp_err_q;
    timer_d       = '0;
`endif

    unique case (state_q)
      // DONE issues the next queued command itself, which keeps the
      // back-to-back gap on bus_request at exactly one cycle.
      IDLE, DONE: begin
        state_d = IDLE;
        if (have_cmd) begin
          state_d       = REQ;
          bus_request_d = 1'b1;
          bus_rw_d      = next_cmd.rw;
          bus_address_d = next_cmd.addr;
          bus_data_in_d = next_cmd.data;
        end
      end
      REQ: begin
        if (bif.bus_grant) begin
          state_d       = DONE;
          pop           = 1'b1;
          bus_request_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rw_d      = bus_rw_q;
          rsp_data_d    = (bus_rw_q == RW_READ) ? bif.bus_data_out : '0;
`ifdef BUS_MASTER_TIMEOUT_EN
          rsp_err_d     = 1'b0;
        end else if (timer_q == TIMER_W'(TIMEOUT)) begin
          state_d       = DONE;
          pop           = 1'b1;
          bus_request_d = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rw_d      = bus_rw_q;
          rsp_data_d    = '0;
          rsp_err_d     = 1'b1;
        end else begin
          timer_d       = timer_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bus_request_q <= 1'b0;
      bus_rw_q      <= 1'b0;
      bus_address_q <= '0;
      bus_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_data_q    <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      rsp_err_q     <= 1'b0;
      timer_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bus_request_q <= bus_request_d;
      bus_rw_q      <= bus_rw_d;
      bus_address_q <= bus_address_d;
      bus_data_in_q <= bus_data_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rw_q      <= rsp_rw_d;
      rsp_data_q    <= rsp_data_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      rsp_err_q     <= rsp_err_d;
      timer_q       <= timer_d;
`endif
    end
  end

  assign bif.cmd_ready   = !full;
  assign bif.bus_request = bus_request_q;
  assign bif.bus_rw      = bus_rw_q;
  assign bif.bus_address = bus_address_q;
  assign bif.bus_data_in = bus_data_in_q;
  assign bif.rsp_valid   = rsp_valid_q;
  assign bif.rsp_rw      = rsp_rw_q;
  assign bif.rsp_data    = rsp_data_q;
`ifdef BUS_MASTER_TIMEOUT_EN
  assign bif.rsp_err     = rsp_err_q;
`else
  assign bif.rsp_err     = 1'b0;
`endif

endmodule
